// File: rtl/d_inst_buffer_pkg.sv
// Shared decode-stage types for the instruction buffer.
// Entry layout, default depth and a 2-bit popcount helper.
package d_inst_buffer_pkg;

    localparam int D_IBUF_DEPTH = 8;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } ibuf_entry_t;

    function automatic logic [1:0] popcnt2(input logic [1:0] m);
        return {1'b0, m[0]} + {1'b0, m[1]};
    endfunction

endpackage

// File: rtl/d_ibuf_compact.sv
// Packs a masked 2-wide fetch packet into contiguous write data.
// wdata[0] is always the oldest valid instruction; wcnt is 0..2.
module d_ibuf_compact
    import d_inst_buffer_pkg::*;
(
    input  logic [1:0]        mask,
    input  logic [1:0][31:0]  pc,
    input  logic [1:0][31:0]  inst,
    output ibuf_entry_t [1:0] wdata,
    output logic [1:0]        wcnt
);

    ibuf_entry_t slot0;
    ibuf_entry_t slot1;

    always_comb begin
        slot0    = '{pc: pc[0], inst: inst[0]};
        slot1    = '{pc: pc[1], inst: inst[1]};
        wdata[1] = slot1;
        wdata[0] = mask[0] ? slot0 : slot1;
        wcnt     = popcnt2(mask);
    end

endmodule

// File: rtl/d_inst_buffer.sv
// Decode-stage instruction buffer: 2-wide in, 2-wide out circular queue.
// Optional perf counters when D_IBUF_PERF_EN is defined.
module d_inst_buffer
    import d_inst_buffer_pkg::*;
#(
    parameter int DEPTH = D_IBUF_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush_i,
    input  logic                     f_valid_i,
    output logic                     f_ready_o,
    input  logic [1:0]               f_mask_i,
    input  logic [1:0][31:0]         f_pc_i,
    input  logic [1:0][31:0]         f_inst_i,
    output logic [1:0]               d_valid_o,
    input  logic                     d_ready_i,
    output logic [1:0][31:0]         d_pc_o,
    output logic [1:0][31:0]         d_inst_o,
`ifdef D_IBUF_PERF_EN
    output logic [31:0]              stall_cnt_o,
    output logic [31:0]              starve_cnt_o,
`endif
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic [CW-1:0] count;
    ibuf_entry_t   mem [DEPTH];

    ibuf_entry_t [1:0] wdata;
    logic [1:0]        wcnt;
    logic              live;
    logic              enq;
    logic              deq;
    logic [1:0]        enq_n;
    logic [1:0]        deq_n;
    ibuf_entry_t       rd0;
    ibuf_entry_t       rd1;

    d_ibuf_compact u_compact (
        .mask  (f_mask_i),
        .pc    (f_pc_i),
        .inst  (f_inst_i),
        .wdata (wdata),
        .wcnt  (wcnt)
    );

    // Flush and reset both mask the handshakes in the same cycle.
    always_comb begin
        live         = rst_n && !flush_i;
        f_ready_o    = live && (count <= CW'(DEPTH - 2));
        d_valid_o[0] = live && (count != '0);
        d_valid_o[1] = live && (count >= CW'(2));
        enq          = f_valid_i && f_ready_o;
        deq          = d_ready_i && d_valid_o[0];
        enq_n        = enq ? wcnt : 2'd0;
        deq_n        = deq ? (d_valid_o[1] ? 2'd2 : 2'd1) : 2'd0;
        rd0          = mem[head];
        rd1          = mem[head + AW'(1)];
        d_pc_o[0]    = rd0.pc;
        d_pc_o[1]    = rd1.pc;
        d_inst_o[0]  = rd0.inst;
        d_inst_o[1]  = rd1.inst;
        count_o      = count;
    end

    always_ff @(posedge clk) begin
        if (!rst_n || flush_i) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + AW'(deq_n);
            tail  <= tail + AW'(enq_n);
            count <= count + CW'(enq_n) - CW'(deq_n);
        end
    end

    always_ff @(posedge clk) begin
        if (enq && wcnt != 2'd0)
            mem[tail] <= wdata[0];
        if (enq && wcnt == 2'd2)
            mem[tail + AW'(1)] <= wdata[1];
    end

`ifdef D_IBUF_PERF_EN
    logic stall_hit;
    logic starve_hit;

    always_comb begin
        stall_hit  = f_valid_i && !f_ready_o && !flush_i;
        starve_hit = d_ready_i && (count == '0) && !flush_i;
    end

    // Saturating; flush deliberately leaves them alone.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt_o  <= '0;
            starve_cnt_o <= '0;
        end else begin
            if (stall_hit && stall_cnt_o != '1)
                stall_cnt_o <= stall_cnt_o + 32'd1;
            if (starve_hit && starve_cnt_o != '1)
                starve_cnt_o <= starve_cnt_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_d_inst_buffer.sv
// Scoreboard bench for d_inst_buffer (DEPTH 8).
module tb_d_inst_buffer;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             flush;
    logic             f_valid;
    logic             f_ready;
    logic [1:0]       f_mask;
    logic [1:0][31:0] f_pc;
    logic [1:0][31:0] f_inst;
    logic [1:0]       d_valid;
    logic             d_ready;
    logic [1:0][31:0] d_pc;
    logic [1:0][31:0] d_inst;
    logic [3:0]       count;
`ifdef D_IBUF_PERF_EN
    logic [31:0]      stall_cnt;
    logic [31:0]      starve_cnt;
`endif

    always #5 clk = ~clk;

    d_inst_buffer #(.DEPTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush_i   (flush),
        .f_valid_i (f_valid),
        .f_ready_o (f_ready),
        .f_mask_i  (f_mask),
        .f_pc_i    (f_pc),
        .f_inst_i  (f_inst),
        .d_valid_o (d_valid),
        .d_ready_i (d_ready),
        .d_pc_o    (d_pc),
        .d_inst_o  (d_inst),
`ifdef D_IBUF_PERF_EN
        .stall_cnt_o  (stall_cnt),
        .starve_cnt_o (starve_cnt),
`endif
        .count_o   (count)
    );

    int checks = 0;
    int failures = 0;
    logic [63:0] sb [$];
    logic [63:0] mon_e;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Monitor: every slot consumed must be the next expected entry.
    always @(negedge clk) begin
        if (rst_n && d_ready && d_valid[0]) begin
            for (int s = 0; s < 2; s++) begin
                if (d_valid[s]) begin
                    if (sb.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL sb_underflow actual=%h required=none",
                                 d_pc[s]);
                    end else begin
                        mon_e = sb.pop_front();
                        chk("out_stream", {d_pc[s], d_inst[s]}, mon_e);
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [1:0] m, input logic [31:0] p0,
                            input logic [31:0] p1);
        if (m[0]) sb.push_back({p0, ~p0});
        if (m[1]) sb.push_back({p1, ~p1});
    endtask

    // Drive one packet that is expected to be accepted.
    task automatic send(input logic [1:0] m, input logic [31:0] p0,
                        input logic [31:0] p1);
        f_valid = 1'b1;
        f_mask  = m;
        f_pc    = {p1, p0};
        f_inst  = {~p1, ~p0};
        push_exp(m, p0, p1);
        @(negedge clk);
        chk("send_ready", f_ready, 1'b1);
        step();
        f_valid = 1'b0;
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        step();
        d_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (count == 4'd0) begin
                done = 1'b1;
                break;
            end
            step();
        end
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout actual=%0d required=0", count);
        end
        step();
        d_ready = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    logic [1:0] masks [20] = '{2'b11, 2'b01, 2'b10, 2'b00, 2'b11,
                               2'b10, 2'b01, 2'b11, 2'b11, 2'b00,
                               2'b10, 2'b01, 2'b11, 2'b10, 2'b11,
                               2'b01, 2'b11, 2'b11, 2'b10, 2'b01};
    logic [31:0] pat = 32'hB5A3_6C9D;
    int mcount, idx, cyc, enq_n, deq_n;
    logic [31:0] p0, p1;
`ifdef D_IBUF_PERF_EN
    logic [31:0] base;
`endif

    initial begin
        rst_n   = 1'b0;
        flush   = 1'b0;
        f_valid = 1'b0;
        f_mask  = 2'b00;
        f_pc    = '0;
        f_inst  = '0;
        d_ready = 1'b0;

        @(negedge clk);
        chk("rst_ready", f_ready, 1'b0);
        chk("rst_dvalid", d_valid, 2'b00);
        step();
        step();
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", f_ready, 1'b1);
        chk("post_rst_dvalid", d_valid, 2'b00);
        chk("post_rst_count", count, 4'd0);
        step();

        // Full packet, downstream stalled.
        send(2'b11, 32'h1c00_0000, 32'h1c00_0004);
        @(negedge clk);
        chk("t1_dvalid", d_valid, 2'b11);
        chk("t1_pc0", d_pc[0], 32'h1c00_0000);
        chk("t1_pc1", d_pc[1], 32'h1c00_0004);
        chk("t1_count", count, 4'd2);
        drain();

        // Slot-1-only packet lands in slot 0.
        send(2'b10, 32'h0, 32'h1c00_0014);
        @(negedge clk);
        chk("t2_dvalid", d_valid, 2'b01);
        chk("t2_pc0", d_pc[0], 32'h1c00_0014);
        chk("t2_count", count, 4'd1);
        drain();

        // Fill to DEPTH.
        for (int i = 0; i < 4; i++)
            send(2'b11, 32'h3000_0000 + 32'(i * 8),
                 32'h3000_0004 + 32'(i * 8));
        @(negedge clk);
        chk("full_count", count, 4'd8);
        chk("full_ready", f_ready, 1'b0);
        step();
        d_ready = 1'b1;
        step();
        d_ready = 1'b0;
        @(negedge clk);
        chk("deq2_count", count, 4'd6);
        chk("deq2_ready", f_ready, 1'b1);
        drain();

        // DEPTH-1 refuses even a single-slot packet.
        send(2'b11, 32'h4000_0000, 32'h4000_0004);
        send(2'b11, 32'h4000_0008, 32'h4000_000c);
        send(2'b11, 32'h4000_0010, 32'h4000_0014);
        send(2'b01, 32'h4000_0018, 32'h0);
        f_valid = 1'b1;
        f_mask  = 2'b01;
        f_pc    = {32'h0, 32'h4000_0020};
        f_inst  = '0;
        @(negedge clk);
        chk("d7_count", count, 4'd7);
        chk("d7_ready", f_ready, 1'b0);
        step();
        f_valid = 1'b0;
        @(negedge clk);
        chk("d7_hold", count, 4'd7);
        drain();

        // Wrap-around stream with a count model.
        mcount = 0;
        idx    = 0;
        cyc    = 0;
        while (idx < 20 && cyc < 300) begin
            p0      = 32'h2000_0000 + 32'(idx) * 8;
            p1      = p0 + 32'd4;
            f_valid = 1'b1;
            f_mask  = masks[idx];
            f_pc    = {p1, p0};
            f_inst  = {~p1, ~p0};
            d_ready = pat[cyc % 32];
            @(negedge clk);
            chk("rnd_count", count, 64'(mcount));
            chk("rnd_ready", f_ready, (8 - mcount >= 2));
            enq_n = 0;
            if (8 - mcount >= 2) begin
                push_exp(masks[idx], p0, p1);
                enq_n = int'(masks[idx][0]) + int'(masks[idx][1]);
                idx++;
            end
            deq_n = d_ready ? ((mcount >= 2) ? 2 : mcount) : 0;
            mcount = mcount + enq_n - deq_n;
            step();
            cyc++;
        end
        f_valid = 1'b0;
        d_ready = 1'b0;
        if (idx < 20) begin
            checks++;
            failures++;
            $display("FAIL rnd_timeout actual=%0d required=20", idx);
        end
        drain();

        // Flush with five entries, concurrent enqueue and dequeue.
        send(2'b11, 32'h5000_0000, 32'h5000_0004);
        send(2'b11, 32'h5000_0008, 32'h5000_000c);
        send(2'b01, 32'h5000_0010, 32'h0);
        @(negedge clk);
        chk("fl_pre_count", count, 4'd5);
        step();
        flush   = 1'b1;
        f_valid = 1'b1;
        f_mask  = 2'b11;
        d_ready = 1'b1;
        @(negedge clk);
        chk("fl_ready", f_ready, 1'b0);
        chk("fl_dvalid", d_valid, 2'b00);
        step();
        flush   = 1'b0;
        f_valid = 1'b0;
        d_ready = 1'b0;
        sb.delete();
        @(negedge clk);
        chk("fl_count", count, 4'd0);
        chk("fl_post_dvalid", d_valid, 2'b00);
        step();
        send(2'b11, 32'h6000_0000, 32'h6000_0004);
        drain();

`ifdef D_IBUF_PERF_EN
        for (int i = 0; i < 4; i++)
            send(2'b11, 32'h7000_0000 + 32'(i * 8),
                 32'h7000_0004 + 32'(i * 8));
        base    = stall_cnt;
        f_valid = 1'b1;
        f_mask  = 2'b11;
        f_pc    = '0;
        step();
        step();
        step();
        f_valid = 1'b0;
        @(negedge clk);
        chk("stall_cnt", stall_cnt - base, 32'd3);
        drain();
        base    = starve_cnt;
        d_ready = 1'b1;
        step();
        step();
        step();
        step();
        d_ready = 1'b0;
        @(negedge clk);
        chk("starve_cnt", starve_cnt - base, 32'd4);
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        @(negedge clk);
        chk("perf_no_flush_clr", starve_cnt - base, 32'd4);
`endif

        step();
        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
